// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to the I-cache,
// buffers returned instructions in a small FIFO toward decode and handles
// redirects, including one that lands while a miss is outstanding.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        icache_read,
  output logic [31:0] icache_addr,
  input  logic [31:0] icache_rdata,
  input  logic        icache_hit,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_misalign
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   tgt_q, tgt_d;
  logic              pend_q, pend_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [XLEN-1:0]   mem_pc_q    [FIFO_DEPTH];
  logic [XLEN-1:0]   mem_instr_q [FIFO_DEPTH];

  logic              fifo_full;
  logic              hit;
  logic              push;
  logic              pop;
  logic [XLEN-1:0]   redir_tgt;

  // Request, handshake and FIFO-head signals derived from registered state
  always_comb begin
    redir_tgt      = {redirect_pc[XLEN-1:2], 2'b00};
    fetch_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
    fifo_full      = (cnt_q == CNT_W'(FIFO_DEPTH));
    icache_read    = (state_q == S_DRAIN) ||
                     ((state_q == S_FETCH) && (!fifo_full || pend_q));
    icache_addr    = pc_q;
    hit            = icache_read && icache_hit;
    if_valid       = (cnt_q != '0) && !redirect_valid;
    if_pc          = mem_pc_q[rptr_q];
    if_instr       = mem_instr_q[rptr_q];
    pop            = if_valid && if_ready;
    push           = (state_q == S_FETCH) && hit && !redirect_valid;
  end

  // Fetch sequencing: PC advance, redirect handling and miss draining
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    pend_d  = pend_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        pend_d  = 1'b0;
        if (redirect_valid) pc_d = redir_tgt;
      end
      S_FETCH: begin
        pend_d = icache_read && !hit;
        if (redirect_valid) begin
          pend_d = 1'b0;
          if (icache_read && !hit) begin
            // Request is on the bus; it must complete before the PC may move
            tgt_d   = redir_tgt;
            state_d = S_DRAIN;
          end else begin
            pc_d = redir_tgt;
          end
        end else if (hit) begin
          pc_d = pc_q + XLEN'(4);
        end
      end
      S_DRAIN: begin
        pend_d = 1'b0;
        if (redirect_valid) tgt_d = redir_tgt;
        if (hit) begin
          pc_d    = redirect_valid ? redir_tgt : tgt_q;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
        pend_d  = 1'b0;
      end
    endcase
  end

  // FIFO pointer and occupancy update; a redirect empties the buffer
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (redirect_valid) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_W'(1);
      if (pop)  rptr_d = rptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
      pend_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Instruction buffer storage; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[wptr_q]    <= pc_q;
      mem_instr_q[wptr_q] <= icache_rdata;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: queue-based fetch model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ifetch_unit;

  localparam int unsigned FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icache_read;
  logic [31:0] icache_addr;
  logic [31:0] icache_rdata;
  logic        icache_hit;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_misalign;

  int checks = 0;
  int errors = 0;

  ifetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .icache_read    (icache_read),
    .icache_addr    (icache_addr),
    .icache_rdata   (icache_rdata),
    .icache_hit     (icache_hit),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_misalign (fetch_misalign)
  );

  always #5 clk = ~clk;

  // Cache content: a fixed scramble of the word address
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  assign icache_rdata = instr_of(icache_addr);

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: next fetch address, drain flag and instruction queue
  logic [63:0] mq[$];
  logic        m_warm;
  logic        m_drain;
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  logic        e_read;
  logic        e_valid;

  initial begin : model
    logic        hit;
    logic        pop;
    logic [31:0] tgt;
    m_warm  = 1'b0;
    m_drain = 1'b0;
    m_pc    = 32'h0;
    m_tgt   = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        e_read  = 1'b0;
        e_valid = 1'b0;
      end else begin
        e_read  = m_warm && (m_drain || (mq.size() < FIFO_DEPTH));
        e_valid = (mq.size() != 0) && !redirect_valid;
      end
      check32("m_icache_read", 32'(icache_read), 32'(e_read));
      if (e_read) check32("m_icache_addr", icache_addr, m_pc);
      check32("m_if_valid", 32'(if_valid), 32'(e_valid));
      if (e_valid) begin
        check32("m_if_pc", if_pc, mq[0][63:32]);
        check32("m_if_instr", if_instr, mq[0][31:0]);
      end
      check32("m_misalign", 32'(fetch_misalign),
              32'(redirect_valid && (redirect_pc[1:0] != 2'b00)));

      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
        m_warm  = 1'b0;
        m_drain = 1'b0;
        m_pc    = 32'h0;
      end else begin
        hit = e_read && icache_hit;
        pop = e_valid && if_ready;
        tgt = {redirect_pc[31:2], 2'b00};
        if (redirect_valid) mq.delete();
        else if (pop) mq.delete(0);
        if (!m_warm) begin
          m_warm = 1'b1;
          if (redirect_valid) m_pc = tgt;
        end else if (m_drain) begin
          if (redirect_valid) m_tgt = tgt;
          if (hit) begin
            m_pc    = m_tgt;
            m_drain = 1'b0;
          end
        end else if (redirect_valid) begin
          if (e_read && !hit) begin
            m_tgt   = tgt;
            m_drain = 1'b1;
          end else begin
            m_pc = tgt;
          end
        end else if (hit) begin
          mq.push_back({m_pc, instr_of(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // One stimulus cycle: drive after the edge, return at the falling edge
  task automatic cyc(input logic h, input logic r, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    icache_hit     = h;
    if_ready       = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog t=%0t got running want finished", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n = 1'b0;
    icache_hit = 1'b0;
    if_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(negedge clk);
    check32("rst_read", 32'(icache_read), 32'h0);
    check32("rst_valid", 32'(if_valid), 32'h0);
    check32("rst_misalign", 32'(fetch_misalign), 32'h0);

    // Reset release with continuous hits
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    icache_hit = 1'b1;
    if_ready = 1'b1;
    @(negedge clk);                                  // k=0
    check32("t1_idle_read", 32'(icache_read), 32'h0);
    cyc(1, 1, 0, 32'h0);                             // k=1
    check32("t1_first_read", 32'(icache_read), 32'h1);
    check32("t1_first_addr", icache_addr, 32'h0);
    check32("t1_valid_k1", 32'(if_valid), 32'h0);
    cyc(1, 1, 0, 32'h0);                             // k=2
    check32("t1_valid_k2", 32'(if_valid), 32'h1);
    check32("t1_pc_k2", if_pc, 32'h0);
    cyc(1, 1, 0, 32'h0);                             // k=3
    check32("t1_pc_k3", if_pc, 32'h4);
    cyc(1, 1, 0, 32'h0);                             // k=4
    check32("t1_pc_k4", if_pc, 32'h8);

    // Miss on 0x10: hit withheld 5 cycles
    for (int k = 5; k <= 10; k++) begin
      cyc(k == 10, 1, 0, 32'h0);
      check32("t2_read_held", 32'(icache_read), 32'h1);
      check32("t2_addr_held", icache_addr, 32'h10);
    end
    cyc(0, 1, 0, 32'h0);                             // k=11
    check32("t2_pc_k11", if_pc, 32'h10);
    check32("t2_addr_k11", icache_addr, 32'h14);
    cyc(1, 0, 0, 32'h0);                             // k=12
    check32("t2_one_push", 32'(if_valid), 32'h0);

    // Decode stalled: FIFO fills, requests stop, then resume in order
    cyc(1, 0, 0, 32'h0);                             // k=13
    check32("t3_addr_k13", icache_addr, 32'h18);
    cyc(1, 0, 0, 32'h0);                             // k=14
    check32("t3_full_read", 32'(icache_read), 32'h0);
    cyc(1, 0, 0, 32'h0);                             // k=15
    check32("t3_head_hold", if_pc, 32'h14);
    cyc(1, 1, 0, 32'h0);                             // k=16
    check32("t3_read_k16", 32'(icache_read), 32'h0);
    cyc(1, 1, 0, 32'h0);                             // k=17
    check32("t3_resume_addr", icache_addr, 32'h1C);
    check32("t3_pc_k17", if_pc, 32'h18);
    cyc(1, 1, 0, 32'h0);                             // k=18
    check32("t3_pc_k18", if_pc, 32'h1C);

    // Redirect to 0x200 during miss on 0x40
    for (int k = 19; k <= 25; k++) cyc(1, 1, 0, 32'h0);
    cyc(0, 0, 0, 32'h0);                             // k=26
    check32("t4_addr_miss", icache_addr, 32'h40);
    check32("t4_pc_k26", if_pc, 32'h3C);
    cyc(0, 0, 1, 32'h200);                           // k=27
    check32("t4_valid_forced", 32'(if_valid), 32'h0);
    check32("t4_addr_k27", icache_addr, 32'h40);
    cyc(0, 1, 0, 32'h0);                             // k=28
    check32("t4_flushed", 32'(if_valid), 32'h0);
    check32("t4_drain_addr", icache_addr, 32'h40);
    cyc(0, 1, 0, 32'h0);                             // k=29
    cyc(1, 1, 0, 32'h0);                             // k=30
    check32("t4_drain_hit_addr", icache_addr, 32'h40);
    cyc(1, 1, 0, 32'h0);                             // k=31
    check32("t4_target_addr", icache_addr, 32'h200);
    check32("t4_dropped", 32'(if_valid), 32'h0);
    cyc(1, 1, 0, 32'h0);                             // k=32
    check32("t4_target_pc", if_pc, 32'h200);

    // Misaligned redirect
    cyc(1, 1, 1, 32'h103);                           // k=33
    check32("t5_misalign_on", 32'(fetch_misalign), 32'h1);
    cyc(1, 1, 0, 32'h0);                             // k=34
    check32("t5_misalign_off", 32'(fetch_misalign), 32'h0);
    check32("t5_aligned_addr", icache_addr, 32'h100);

    // PC wrap, then reset asserted mid-miss
    cyc(1, 1, 1, 32'hFFFF_FFF8);                     // k=35
    cyc(1, 1, 0, 32'h0);                             // k=36
    check32("t6_addr_fff8", icache_addr, 32'hFFFF_FFF8);
    cyc(1, 1, 0, 32'h0);                             // k=37
    check32("t6_addr_fffc", icache_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 32'h0);                             // k=38
    check32("t6_wrap_addr", icache_addr, 32'h0);
    check32("t6_head_fffc", if_pc, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 32'h0);                             // k=39
    check32("t6_pre_rst_read", 32'(icache_read), 32'h1);
    check32("t6_pre_rst_valid", 32'(if_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check32("t6_async_read", 32'(icache_read), 32'h0);
    check32("t6_async_valid", 32'(if_valid), 32'h0);
    cyc(0, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0);

    // Restart after reset fetches from the reset PC again
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    icache_hit = 1'b1;
    if_ready = 1'b1;
    @(negedge clk);
    cyc(1, 1, 0, 32'h0);
    check32("t6_restart_addr", icache_addr, 32'h0);
    cyc(1, 1, 0, 32'h0);
    cyc(1, 1, 0, 32'h0);
    check32("t6_restart_pc", if_pc, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
